// File: rtl/ecc_mul_pkg.sv
// rtl/ecc_mul_pkg.sv - shared constants and loader FSM encoding for the ECC multiplier
package ecc_mul_pkg;

   localparam int ECC_W      = 17;
   localparam int ECC_NWORDS = 14;
   localparam int ECC_OPW    = ECC_W * ECC_NWORDS;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      START  = 2'd2,
      WAIT   = 2'd3
   } loader_state_t;

endpackage

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - streams 14+14 operand words into the multiplier shift registers (optional OPERAND_LOADER_PARITY_EN)
module operand_loader
   import ecc_mul_pkg::*;
#(
   parameter int W      = ECC_W,
   parameter int NWORDS = ECC_NWORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
`ifdef OPERAND_LOADER_PARITY_EN
   input  logic         in_par,
   output logic         par_err,
   output logic         frame_drop,
`endif
   output logic [W-1:0] shift_data,
   output logic         sel_a,
   output logic         sel_b,
   output logic         mul_start,
   input  logic         mul_done,
   output logic         busy
);

   localparam int CW = $clog2(NWORDS);

   loader_state_t state;
   logic [CW-1:0] cnt;
   logic          beat;
   logic          last_word;
   logic          bad_word;

`ifdef OPERAND_LOADER_PARITY_EN
   // frame_err remembers a bad beat anywhere in the current A+B frame;
   // drop_pend delays the drop pulse so it lines up with where mul_start would be
   logic frame_err;
   logic drop_pend;
   assign bad_word = ^{in_data, in_par};
`else
   assign bad_word = 1'b0;
`endif

   assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
   assign busy      = (state == START) || (state == WAIT);
   assign beat      = in_valid && in_ready;
   assign last_word = (cnt == CW'(NWORDS - 1));

   // Loader FSM: word counting, shift-enable generation and multiply handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD_A;
         cnt        <= '0;
         shift_data <= '0;
         sel_a      <= 1'b0;
         sel_b      <= 1'b0;
         mul_start  <= 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
         par_err    <= 1'b0;
         frame_err  <= 1'b0;
         drop_pend  <= 1'b0;
         frame_drop <= 1'b0;
`endif
      end else begin
         sel_a     <= 1'b0;
         sel_b     <= 1'b0;
         mul_start <= 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
         frame_drop <= drop_pend;
         drop_pend  <= 1'b0;
         if (beat && bad_word) begin
            par_err   <= 1'b1;
            frame_err <= 1'b1;
         end
`endif
         case (state)
            LOAD_A: begin
               if (beat) begin
                  shift_data <= in_data;
                  sel_a      <= 1'b1;
                  if (last_word) begin
                     cnt   <= '0;
                     state <= LOAD_B;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (beat) begin
                  shift_data <= in_data;
                  sel_b      <= 1'b1;
                  if (last_word) begin
                     cnt <= '0;
`ifdef OPERAND_LOADER_PARITY_EN
                     if (frame_err || bad_word) begin
                        // corrupted frame: keep framing, skip the multiply
                        state     <= LOAD_A;
                        drop_pend <= 1'b1;
                        frame_err <= 1'b0;
                     end else begin
                        state <= START;
                     end
`else
                     state <= START;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            START: begin
               mul_start <= 1'b1;
               state     <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  state <= LOAD_A;
               end
            end
            default: begin
               state <= LOAD_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader with shift-register model
module tb_operand_loader;

   localparam int W      = 17;
   localparam int NWORDS = 14;
   localparam int OPW    = W * NWORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [W-1:0]  shift_data;
   logic          sel_a;
   logic          sel_b;
   logic          mul_start;
   logic          mul_done;
   logic          busy;
`ifdef OPERAND_LOADER_PARITY_EN
   logic          in_par;
   logic          par_err;
   logic          frame_drop;
   logic          exp_par_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [OPW-1:0] op_a;
   logic [OPW-1:0] op_b;

   operand_loader #(.W(W), .NWORDS(NWORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
`ifdef OPERAND_LOADER_PARITY_EN
      .in_par     (in_par),
      .par_err    (par_err),
      .frame_drop (frame_drop),
`endif
      .shift_data (shift_data),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .mul_start  (mul_start),
      .mul_done   (mul_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Downstream operand registers: shift right, new word enters at the top
   always @(posedge clk) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
      end else begin
         if (sel_a) op_a <= {shift_data, op_a[OPW-1:W]};
         if (sel_b) op_b <= {shift_data, op_b[OPW-1:W]};
      end
   end

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = W'($urandom);
      mul_done = 1'b1;
`ifdef OPERAND_LOADER_PARITY_EN
      in_par      = 1'b0;
      exp_par_err = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({shift_data, sel_a, sel_b, mul_start, busy, in_ready} !== {{W{1'b0}}, 4'b0000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_outputs: got sd=%h a=%b b=%b st=%b busy=%b rdy=%b, want all 0 and rdy=1",
                  shift_data, sel_a, sel_b, mul_start, busy, in_ready);
      end
      n_checks++;
      if (dut.cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d want 0", dut.cnt);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      mul_done = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({sel_a, sel_b, mul_start, busy, in_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_release: got a=%b b=%b st=%b busy=%b rdy=%b want 0 0 0 0 1",
                  sel_a, sel_b, mul_start, busy, in_ready);
      end
   endtask

   // Feeds one A+B frame and checks every cycle against the beat history
   task automatic load_operands(input bit toggle, input bit ramp, input bit done_in_start, input int bad_idx);
      logic [W-1:0]   words [2*NWORDS];
      logic [OPW-1:0] exp_a;
      logic [OPW-1:0] exp_b;
      logic [W-1:0]   last_sd;
      bit             have_last;
      bit             acc;
      bit             drop;
      bit             ea;
      bit             eb;
      int             idx;
      int             cyc;
      drop      = (bad_idx >= 0);
      have_last = 1'b0;
      last_sd   = '0;
      for (int i = 0; i < 2*NWORDS; i++) begin
         if (ramp) words[i] = (i < NWORDS) ? W'(i + 1) : W'(32'h10000 + i - NWORDS + 1);
         else      words[i] = W'($urandom);
      end
      for (int i = 0; i < NWORDS; i++) begin
         exp_a[i*W +: W] = words[i];
         exp_b[i*W +: W] = words[i+NWORDS];
      end
      idx = 0;
      cyc = 0;
      while (idx < 2*NWORDS && cyc < 400) begin
         in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         in_data  = in_valid ? words[idx] : W'($urandom);
         mul_done = in_valid ? 1'b0 : 1'($urandom_range(0, 1));
`ifdef OPERAND_LOADER_PARITY_EN
         in_par = (^in_data) ^ (in_valid && idx == bad_idx);
`endif
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: word %0d got in_ready=%b want 1", idx, in_ready);
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         ea = acc && (idx < NWORDS);
         eb = acc && (idx >= NWORDS);
         if (acc) begin
            last_sd   = words[idx];
            have_last = 1'b1;
`ifdef OPERAND_LOADER_PARITY_EN
            if (idx == bad_idx) exp_par_err = 1'b1;
`endif
            idx++;
         end
         if (have_last) begin
            n_checks++;
            if ({sel_a, sel_b, shift_data} !== {ea, eb, last_sd}) begin
               n_fail++;
               $display("FAIL load_sel: cyc %0d got a=%b b=%b sd=%h want a=%b b=%b sd=%h",
                        cyc, sel_a, sel_b, shift_data, ea, eb, last_sd);
            end
         end
      end
      in_valid = 1'b0;
      mul_done = 1'b0;
      if (idx < 2*NWORDS) begin
         n_checks++;
         n_fail++;
         $display("FAIL load_timeout: accepted %0d words want %0d", idx, 2*NWORDS);
      end
      // cycle after the last B beat
      n_checks++;
      if ({in_ready, busy, mul_start} !== {drop, !drop, 1'b0}) begin
         n_fail++;
         $display("FAIL after_last: got rdy=%b busy=%b st=%b want rdy=%b busy=%b st=0",
                  in_ready, busy, mul_start, drop, !drop);
      end
      mul_done = done_in_start;
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      n_checks++;
      if ({mul_start, sel_b} !== {!drop, 1'b0}) begin
         n_fail++;
         $display("FAIL mul_start: got st=%b b=%b want st=%b b=0", mul_start, sel_b, !drop);
      end
      n_checks++;
      if (op_a !== exp_a || op_b !== exp_b) begin
         n_fail++;
         $display("FAIL operands: got a[16:0]=%h b[237:221]=%h want %h %h",
                  op_a[W-1:0], op_b[OPW-1 -: W], exp_a[W-1:0], exp_b[OPW-1 -: W]);
      end
`ifdef OPERAND_LOADER_PARITY_EN
      n_checks++;
      if ({frame_drop, par_err} !== {drop, exp_par_err}) begin
         n_fail++;
         $display("FAIL parity_flags: got drop=%b perr=%b want %b %b", frame_drop, par_err, drop, exp_par_err);
      end
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if ({mul_start, busy, in_ready} !== {1'b0, !drop, drop}) begin
         n_fail++;
         $display("FAIL start_once: got st=%b busy=%b rdy=%b want 0 %b %b", mul_start, busy, in_ready, !drop, drop);
      end
`ifdef OPERAND_LOADER_PARITY_EN
      n_checks++;
      if (frame_drop !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_pulse: got %b want 0", frame_drop);
      end
`endif
   endtask

   // Holds in_valid high while waiting, then releases with mul_done
   task automatic test_wait_block(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         @(posedge clk);
         #1;
         n_checks++;
         if ({in_ready, sel_a, sel_b, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL wait_block: cyc %0d got rdy=%b a=%b b=%b busy=%b want 0 0 0 1",
                     i, in_ready, sel_a, sel_b, busy);
         end
      end
      in_valid = 1'b0;
      mul_done = 1'b1;
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      n_checks++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL wait_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_ramp();
      load_operands(1'b0, 1'b1, 1'b0, -1);
      test_wait_block(20);
   endtask

   task automatic test_toggle();
      load_operands(1'b1, 1'b0, 1'b0, -1);
      test_wait_block(2);
   endtask

   task automatic test_reset_midload();
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_data = W'($urandom);
`ifdef OPERAND_LOADER_PARITY_EN
         in_par = ^in_data;
`endif
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
      exp_par_err = 1'b0;
`endif
      n_checks++;
      if ({shift_data, sel_a, sel_b, mul_start, busy, in_ready} !== {{W{1'b0}}, 4'b0000, 1'b1}) begin
         n_fail++;
         $display("FAIL midload_reset: got sd=%h a=%b b=%b st=%b busy=%b rdy=%b want 0s rdy=1",
                  shift_data, sel_a, sel_b, mul_start, busy, in_ready);
      end
      n_checks++;
      if (dut.cnt !== '0) begin
         n_fail++;
         $display("FAIL midload_cnt: got %0d want 0", dut.cnt);
      end
      load_operands(1'b0, 1'b0, 1'b0, -1);
      test_wait_block(1);
   endtask

   task automatic test_done_ignored();
      in_valid = 1'b0;
      mul_done = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL done_in_load: got rdy=%b busy=%b want 1 0", in_ready, busy);
         end
      end
      mul_done = 1'b0;
      load_operands(1'b1, 1'b0, 1'b1, -1);
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({in_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL done_in_start: got rdy=%b busy=%b want 0 1", in_ready, busy);
         end
      end
      test_wait_block(1);
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         load_operands(1'b0, 1'b0, 1'b0, -1);
         test_wait_block(0);
      end
   endtask

`ifdef OPERAND_LOADER_PARITY_EN
   task automatic test_parity();
      load_operands(1'b0, 1'b0, 1'b0, NWORDS + 5);
      load_operands(1'b0, 1'b0, 1'b0, -1);
      test_wait_block(1);
   endtask
`endif

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      mul_done = 1'b0;
`ifdef OPERAND_LOADER_PARITY_EN
      in_par      = 1'b0;
      exp_par_err = 1'b0;
`endif
      test_reset();
      test_ramp();
      test_toggle();
      test_reset_midload();
      test_done_ignored();
      test_back_to_back();
`ifdef OPERAND_LOADER_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the ECC multiplier's two 238-bit operand shift registers. Accepts operand words on a 17-bit valid/ready stream: 14 words of operand A, then 14 words of operand B, least-significant word first. It drives the shared shift data and per-register shift-enables, then issues a one-cycle multiply start. It blocks further input until the multiplier reports completion.

## Interface
Parameters:
- `W`, 17, word width; equals the operand registers' shift-in width.
- `NWORDS`, 14, words per operand; W*NWORDS = 238.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  W  operand word.
- `shift_data`  out  W  word presented to both operand registers.
- `sel_a`  out  1  shift-enable, operand A register.
- `sel_b`  out  1  shift-enable, operand B register.
- `mul_start`  out  1  one-cycle pulse: both operands loaded.
- `mul_done`  in  1  multiplier finished; honoured only in WAIT.
- `busy`  out  1  high in START and WAIT.

## Operation
- FSM states:
  - LOAD_A (reset state)
  - LOAD_B
  - START
  - WAIT
- Word counter `cnt`, $clog2(NWORDS) bits, reset 0.
- A beat is accepted when `in_valid && in_ready`. `in_ready` = (state == LOAD_A || state == LOAD_B), decoded combinationally from the state register. It does not depend on `in_valid`.
- Accepted beat in LOAD_A:
  - next cycle: `shift_data` = `in_data`, `sel_a` = 1, `sel_b` = 0.
  - `cnt` increments. On the beat with `cnt == NWORDS-1`, `cnt` returns to 0 and the FSM moves to LOAD_B.
- LOAD_B is identical but drives `sel_b`. On its last beat the FSM moves to START.
- START lasts one cycle: `mul_start` = 1 (registered, high during the cycle after the state is entered), then go to WAIT.
- WAIT: on `mul_done` = 1, go to LOAD_A. `mul_done` is ignored in every other state.
- `sel_a`/`sel_b` are high only in the cycle after an accepted beat. They are never both high.
- No accepted beat: `sel_a` = `sel_b` = 0. `shift_data` holds its last value.
- Word order: first accepted word lands in operand bits [16:0] after 14 shifts. The last word lands in [237:221].
- Reset, including mid-load: FSM to LOAD_A, `cnt` = 0, and all outputs 0 (`shift_data`, `sel_a`, `sel_b`, `mul_start`, `busy`). The operand registers share `rst` and clear together. A partially loaded operand is discarded.

## Timing
- Beat accepted at edge k: the matching sel is high in cycle k+1, and the operand register updates at edge k+2.
- Back-to-back beats give continuous sel; the full throughput is 1 word/cycle.
- Last B beat at edge k:
  - `sel_b` high in cycle k+1.
  - `mul_start` high in cycle k+2.
  - At that point both registers are complete.
- `in_ready` drops in the cycle after the last B beat and stays low until the cycle after `mul_done` is sampled in WAIT.
- `busy` is high from the START cycle through the last WAIT cycle.
- `mul_done` asserted while the FSM is in START is lost. The multiplier must not complete in under 1 cycle.

## Configuration
- `OPERAND_LOADER_PARITY_EN` defined:
  - Adds input `in_par` (1 bit). Even parity: the XOR of `in_data` and `in_par` must be 0.
  - Adds outputs `par_err` (sticky until `rst`) and `frame_drop` (1-cycle pulse).
  - A bad beat is still accepted and counted, so framing is kept. It sets `par_err` and an internal frame-error flag.
  - On the last B beat with the flag set, the FSM returns to LOAD_A instead of START. `mul_start` is suppressed and `frame_drop` pulses in cycle k+2. The flag clears.
- `OPERAND_LOADER_PARITY_EN` undefined: the extra ports are absent and there is no parity logic.

## Structure
- Shared package `ecc_mul_pkg`:
  - constants `ECC_W` = 17, `ECC_NWORDS` = 14, `ECC_OPW` = 238
  - FSM state enum `loader_state_t`
- Single module. No sub-module is needed; the counter and FSM are inline.

## Test plan
- Reset then 14 A words 0x00001..0x0000E, then 14 B words 0x10001..0x1000E, `in_valid` held high:
  - `sel_a` high 14 consecutive cycles, then `sel_b` 14.
  - `mul_start` pulses once, 2 cycles after the last B beat.
  - A register bits [16:0] = 0x00001.
  - B register bits [237:221] = 0x1000E.
- `in_valid` toggled 1/0 throughout: each sel pulse follows its beat by exactly 1 cycle. No sel is high after an idle cycle.
- During WAIT, `in_valid` = 1 for 20 cycles, then `mul_done` = 1:
  - `in_ready` = 0 and no sel throughout.
  - `in_ready` = 1 in the next cycle.
- `rst` asserted after 7 A words: all outputs 0 and `cnt` = 0. A following full 28-word load produces the correct operands.
- `mul_done` pulsed during LOAD_A, and during the START cycle: no state change. The FSM remains in WAIT.
- Parity build: B word 5 sent with a wrong `in_par`:
  - `par_err` = 1, `frame_drop` pulses, and there is no `mul_start`.
  - The next clean 28-word load gives `mul_start`, and `par_err` stays 1.
